// File: rtl/led_seq_pkg.sv
// Shared types and constants for the led_sequencer LED pattern block.
package led_seq_pkg;

    typedef enum logic [2:0] {
        MODE_OFF       = 3'd0,
        MODE_ON        = 3'd1,
        MODE_BLINK     = 3'd2,
        MODE_HEARTBEAT = 3'd3,
        MODE_BREATHE   = 3'd4
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_TICK = 2'd1,
        ST_APPLY     = 2'd2
    } state_e;

    // Bit n set: heartbeat is lit while phase[3:0] == n (double beat at 0,1 and 4,5).
    localparam logic [15:0] HEARTBEAT_MASK = 16'b0000_0000_0011_0011;

    // Phase bit that splits a blink period into 8 ticks on / 8 ticks off.
    localparam int BLINK_BIT = 3;

endpackage

// File: rtl/led_seq_channel.sv
// led_channel: one LED's mode/level/phase state and its PWM lit decision.
module led_channel
    import led_seq_pkg::*;
#(
    parameter int PWM_BITS = 4
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                tick,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    input  logic                wr_en,
    input  logic [2:0]          wr_mode,
    input  logic [PWM_BITS-1:0] wr_level,
    output logic                lit
);

    logic [2:0]          mode_q,  mode_d;
    logic [PWM_BITS-1:0] level_q, level_d;
    logic [PWM_BITS:0]   phase_q, phase_d;
    logic [PWM_BITS-1:0] tri_wave;
    logic [PWM_BITS-1:0] eff_level;

    // A write always starts the pattern from phase 0 so it begins cleanly.
    always_comb begin
        mode_d  = mode_q;
        level_d = level_q;
        phase_d = phase_q;
        if (wr_en) begin
            mode_d  = wr_mode;
            level_d = wr_level;
            phase_d = '0;
        end else if (tick) begin
            phase_d = phase_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            mode_q  <= MODE_OFF;
            level_q <= '0;
            phase_q <= '0;
        end else begin
            mode_q  <= mode_d;
            level_q <= level_d;
            phase_q <= phase_d;
        end
    end

    always_comb begin
        tri_wave  = phase_q[PWM_BITS] ? ~phase_q[PWM_BITS-1:0] : phase_q[PWM_BITS-1:0];
        eff_level = '0;
        case (mode_q)
            MODE_ON:        eff_level = level_q;
            MODE_BLINK:     eff_level = phase_q[BLINK_BIT] ? '0 : level_q;
            MODE_HEARTBEAT: eff_level = HEARTBEAT_MASK[phase_q[3:0]] ? level_q : '0;
            MODE_BREATHE:   eff_level = (tri_wave < level_q) ? tri_wave : level_q;
            default:        eff_level = '0;
        endcase
    end

    // Full-scale level has no dark PWM slot; otherwise compare against the counter.
    assign lit = (&eff_level) || (pwm_cnt < eff_level);

endmodule

// File: rtl/led_sequencer.sv
// led_sequencer: tick prescaler, shared PWM counter and command FSM driving
// per-LED pattern channels onto an active-low LED bank. Optional LED_SEQ_ALIVE_EN.
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int NUM_LEDS = 4,
    parameter int TICK_DIV = 50000,
    parameter int PWM_BITS = 4
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [$clog2(NUM_LEDS)-1:0] cmd_led,
    input  logic [2:0]                  cmd_mode,
    input  logic [PWM_BITS-1:0]         cmd_level,
    output logic [NUM_LEDS-1:0]         leds,
    output logic                        tick
);

    localparam int LED_W   = $clog2(NUM_LEDS);
    localparam int PRESC_W = $clog2(TICK_DIV);
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);

`ifdef LED_SEQ_ALIVE_EN
    localparam int NUM_CH = NUM_LEDS - 1;
`else
    localparam int NUM_CH = NUM_LEDS;
`endif

    logic [PRESC_W-1:0]  presc_q,   presc_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    state_e              state_q,   state_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic [LED_W-1:0]    cmd_led_q,   cmd_led_d;
    logic [2:0]          cmd_mode_q,  cmd_mode_d;
    logic [PWM_BITS-1:0] cmd_level_q, cmd_level_d;
    logic                apply;
    logic [NUM_CH-1:0]   ch_lit;
    logic [NUM_CH-1:0]   wr_en;
    logic [NUM_LEDS-1:0] lit;
    logic [NUM_LEDS-1:0] leds_q, leds_d;

    always_comb begin
        presc_d   = (presc_q == PRESC_MAX) ? '0 : presc_q + 1'b1;
        pwm_cnt_d = pwm_cnt_q + 1'b1;
    end

    assign tick = (presc_q == PRESC_MAX);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            presc_q   <= '0;
            pwm_cnt_q <= '0;
        end else begin
            presc_q   <= presc_d;
            pwm_cnt_q <= pwm_cnt_d;
        end
    end

    // A tick seen in the acceptance cycle is ignored: IDLE does not look at tick.
    always_comb begin
        state_d     = state_q;
        cmd_led_d   = cmd_led_q;
        cmd_mode_d  = cmd_mode_q;
        cmd_level_d = cmd_level_q;
        apply       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    cmd_led_d   = cmd_led;
                    cmd_mode_d  = cmd_mode;
                    cmd_level_d = cmd_level;
                    state_d     = ST_WAIT_TICK;
                end
            end
            ST_WAIT_TICK: begin
                if (tick) begin
                    state_d = ST_APPLY;
                end
            end
            ST_APPLY: begin
                apply   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        cmd_ready_d = (state_d == ST_IDLE);
    end

    // Registered ready stays low through reset and rises one cycle after release.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

    always_ff @(posedge clk) begin
        cmd_led_q   <= cmd_led_d;
        cmd_mode_q  <= cmd_mode_d;
        cmd_level_q <= cmd_level_d;
    end

    assign cmd_ready = cmd_ready_q;

    // Out-of-range indices match no channel, so the write simply drops.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign wr_en[i] = apply && (int'(cmd_led_q) == i);

        led_channel #(
            .PWM_BITS (PWM_BITS)
        ) u_ch (
            .clk      (clk),
            .rstn     (rstn),
            .tick     (tick),
            .pwm_cnt  (pwm_cnt_q),
            .wr_en    (wr_en[i]),
            .wr_mode  (cmd_mode_q),
            .wr_level (cmd_level_q),
            .lit      (ch_lit[i])
        );
    end

`ifdef LED_SEQ_ALIVE_EN
    logic [PWM_BITS+1:0] alive_cnt_q, alive_cnt_d;

    // Top bit of a tick counter gives a toggle every 2^(PWM_BITS+1) ticks, lit first.
    assign alive_cnt_d = tick ? alive_cnt_q + 1'b1 : alive_cnt_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            alive_cnt_q <= '0;
        end else begin
            alive_cnt_q <= alive_cnt_d;
        end
    end

    assign lit = {~alive_cnt_q[PWM_BITS+1], ch_lit};
`else
    assign lit = ch_lit;
`endif

    assign leds_d = ~lit;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            leds_q <= '1;
        end else begin
            leds_q <= leds_d;
        end
    end

    assign leds = leds_q;

endmodule
